bp_zynq_dram_bridge: RTL and testbench

Downstream of the ZynqParrot BlackParrot core configurations (34-bit paddr, 64-bit BedRock fill width), this block turns the core's BedRock memory-forward stream into AXI4 master bursts on the PS HP DRAM port. It rebases physical addresses into the 32-bit PS DRAM window and returns BedRock memory-reverse beats. It handles one transaction at a time; ordering is trivially preserved.

---
 rtl/bp_zynq_dram_bridge.sv | 248 ++++++++++++++++++++++++
 tb/tb_bp_zynq_dram_bridge.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bp_zynq_dram_bridge.sv
// rtl/bp_zynq_dram_bridge.sv - BedRock memory-forward to AXI4 HP DRAM bridge
//
// Turns one BedRock mem-fwd transaction at a time into an AXI4 burst on the
// Zynq PS DRAM port. The paddr is rebased into the 32-bit DRAM window. The
// AXI response is returned as BedRock mem-rev beats.
//
// Optional feature macro: BP_ZYNQ_DRAM_BOUNDS_CHECK_EN
//   When defined, accesses outside [dram_base_p, dram_base_p+dram_size_p) are
//   drained locally. They raise error_o and return zero data without any AXI
//   traffic.
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   fwd_*                     BedRock forward header/data beats (ready-valid)
//   rev_*                     BedRock reverse header/data beats (ready-valid)
//   m_axi_aw*/w*/b*           AXI4 write address, data and response channels
//   m_axi_ar*/r*              AXI4 read address and data channels
//   error_o                   sticky: out-of-window access or nonzero resp
module bp_zynq_dram_bridge #(
  parameter int paddr_width_p    = 34,
  parameter int axi_addr_width_p = 32,
  parameter int axi_id_width_p   = 6,
  parameter int payload_width_p  = 16,
  parameter logic [paddr_width_p-1:0] dram_base_p = 34'h0_8000_0000,
  parameter logic [paddr_width_p-1:0] dram_size_p = 34'h0_4000_0000
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        fwd_wr_i,
  input  logic [paddr_width_p-1:0]    fwd_addr_i,
  input  logic [2:0]                  fwd_size_i,
  input  logic [payload_width_p-1:0]  fwd_payload_i,
  input  logic [63:0]                 fwd_data_i,
  input  logic                        fwd_last_i,
  input  logic                        fwd_v_i,
  output logic                        fwd_ready_and_o,
  output logic                        rev_wr_o,
  output logic [paddr_width_p-1:0]    rev_addr_o,
  output logic [2:0]                  rev_size_o,
  output logic [payload_width_p-1:0]  rev_payload_o,
  output logic [63:0]                 rev_data_o,
  output logic                        rev_last_o,
  output logic                        rev_v_o,
  input  logic                        rev_ready_and_i,
  output logic [axi_addr_width_p-1:0] m_axi_awaddr_o,
  output logic [axi_id_width_p-1:0]   m_axi_awid_o,
  output logic [7:0]                  m_axi_awlen_o,
  output logic [2:0]                  m_axi_awsize_o,
  output logic [1:0]                  m_axi_awburst_o,
  output logic                        m_axi_awvalid_o,
  input  logic                        m_axi_awready_i,
  output logic [63:0]                 m_axi_wdata_o,
  output logic [7:0]                  m_axi_wstrb_o,
  output logic                        m_axi_wlast_o,
  output logic                        m_axi_wvalid_o,
  input  logic                        m_axi_wready_i,
  input  logic [axi_id_width_p-1:0]   m_axi_bid_i,
  input  logic [1:0]                  m_axi_bresp_i,
  input  logic                        m_axi_bvalid_i,
  output logic                        m_axi_bready_o,
  output logic [axi_addr_width_p-1:0] m_axi_araddr_o,
  output logic [axi_id_width_p-1:0]   m_axi_arid_o,
  output logic [7:0]                  m_axi_arlen_o,
  output logic [2:0]                  m_axi_arsize_o,
  output logic [1:0]                  m_axi_arburst_o,
  output logic                        m_axi_arvalid_o,
  input  logic                        m_axi_arready_i,
  input  logic [63:0]                 m_axi_rdata_i,
  input  logic [axi_id_width_p-1:0]   m_axi_rid_i,
  input  logic [1:0]                  m_axi_rresp_i,
  input  logic                        m_axi_rlast_i,
  input  logic                        m_axi_rvalid_i,
  output logic                        m_axi_rready_o,
  output logic                        error_o
);

  typedef enum logic [2:0] {
    e_ready, e_aw, e_w, e_b, e_ar, e_r, e_err_drain, e_err_resp
  } state_e;

  state_e state_r, state_n;

  logic                       hdr_wr_r;
  logic [paddr_width_p-1:0]   hdr_addr_r;
  logic [2:0]                 hdr_size_r;
  logic [payload_width_p-1:0] hdr_payload_r;
  logic                       error_r;
  logic                       capture;
  logic                       set_error;
  logic                       oob;
  logic [paddr_width_p-1:0]   rel_addr;
  logic [7:0]                 axlen;
  logic [2:0]                 axsize;
  logic [7:0]                 sub_mask;
  logic                       err_last;
  logic                       unused_ok;

`ifdef BP_ZYNQ_DRAM_BOUNDS_CHECK_EN
  logic [paddr_width_p:0] end_addr;
  logic [paddr_width_p:0] win_end;
  logic [7:0]             err_cnt_r;

  // Compute with one extra bit so a window ending at the top of paddr space cannot wrap.
  assign end_addr = {1'b0, fwd_addr_i} + ({{paddr_width_p{1'b0}}, 1'b1} << fwd_size_i);
  assign win_end  = {1'b0, dram_base_p} + {1'b0, dram_size_p};
  assign oob      = (fwd_addr_i < dram_base_p) || (end_addr > win_end);
  // A write gets one reply beat; a read gets one zero beat per burst beat.
  assign err_last = hdr_wr_r || (err_cnt_r == axlen);

  always_ff @(posedge clk_i) begin
    if (reset_i || capture)
      err_cnt_r <= '0;
    else if (state_r == e_err_resp && rev_ready_and_i)
      err_cnt_r <= err_cnt_r + 8'd1;
  end
`else
  assign oob      = 1'b0;
  assign err_last = 1'b1;
`endif

  // The upper address bits above the window are dropped on purpose. The IDs are unused
  // because only one transaction is ever outstanding.
  assign rel_addr  = hdr_addr_r - dram_base_p;
  assign unused_ok = ^{m_axi_bid_i, m_axi_rid_i, dram_size_p,
                       rel_addr[paddr_width_p-1:axi_addr_width_p]};

  assign axlen    = (hdr_size_r >= 3'd3) ? ((8'd1 << (hdr_size_r - 3'd3)) - 8'd1) : 8'd0;
  assign axsize   = (hdr_size_r >= 3'd3) ? 3'd3 : hdr_size_r;
  assign sub_mask = (8'd1 << (4'd1 << hdr_size_r[1:0])) - 8'd1;

  assign m_axi_awaddr_o  = rel_addr[axi_addr_width_p-1:0];
  assign m_axi_awid_o    = '0;
  assign m_axi_awlen_o   = axlen;
  assign m_axi_awsize_o  = axsize;
  assign m_axi_awburst_o = 2'b01;
  assign m_axi_araddr_o  = rel_addr[axi_addr_width_p-1:0];
  assign m_axi_arid_o    = '0;
  assign m_axi_arlen_o   = axlen;
  assign m_axi_arsize_o  = axsize;
  assign m_axi_arburst_o = 2'b01;
  assign m_axi_wdata_o   = fwd_data_i;
  assign m_axi_wstrb_o   = (hdr_size_r >= 3'd3) ? 8'hFF : (sub_mask << hdr_addr_r[2:0]);

  assign rev_wr_o      = hdr_wr_r;
  assign rev_addr_o    = hdr_addr_r;
  assign rev_size_o    = hdr_size_r;
  assign rev_payload_o = hdr_payload_r;
  assign error_o       = error_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r       <= e_ready;
      hdr_wr_r      <= 1'b0;
      hdr_addr_r    <= '0;
      hdr_size_r    <= '0;
      hdr_payload_r <= '0;
      error_r       <= 1'b0;
    end else begin
      state_r <= state_n;
      if (capture) begin
        hdr_wr_r      <= fwd_wr_i;
        hdr_addr_r    <= fwd_addr_i;
        hdr_size_r    <= fwd_size_i;
        hdr_payload_r <= fwd_payload_i;
      end
      if (set_error)
        error_r <= 1'b1;
    end
  end

  always_comb begin
    state_n         = state_r;
    capture         = 1'b0;
    set_error       = 1'b0;
    fwd_ready_and_o = 1'b0;
    rev_v_o         = 1'b0;
    rev_data_o      = '0;
    rev_last_o      = 1'b0;
    m_axi_awvalid_o = 1'b0;
    m_axi_wvalid_o  = 1'b0;
    m_axi_wlast_o   = 1'b0;
    m_axi_bready_o  = 1'b0;
    m_axi_arvalid_o = 1'b0;
    m_axi_rready_o  = 1'b0;
    case (state_r)
      e_ready: begin
        // Peek at the header only; beats are consumed later in e_w, e_ar or e_err_drain.
        if (fwd_v_i) begin
          capture = 1'b1;
          if (oob) begin
            set_error = 1'b1;
            state_n   = e_err_drain;
          end else begin
            state_n = fwd_wr_i ? e_aw : e_ar;
          end
        end
      end
      e_aw: begin
        m_axi_awvalid_o = 1'b1;
        if (m_axi_awready_i) state_n = e_w;
      end
      e_w: begin
        m_axi_wvalid_o  = fwd_v_i;
        m_axi_wlast_o   = fwd_last_i;
        fwd_ready_and_o = m_axi_wready_i;
        if (fwd_v_i && m_axi_wready_i && fwd_last_i) state_n = e_b;
      end
      e_b: begin
        rev_v_o        = m_axi_bvalid_i;
        rev_last_o     = 1'b1;
        m_axi_bready_o = rev_ready_and_i;
        if (m_axi_bvalid_i && rev_ready_and_i) begin
          set_error = (m_axi_bresp_i != 2'b00);
          state_n   = e_ready;
        end
      end
      e_ar: begin
        m_axi_arvalid_o = 1'b1;
        // A read request carries exactly one forward beat; consume it as AR is accepted.
        if (m_axi_arready_i) begin
          fwd_ready_and_o = 1'b1;
          state_n         = e_r;
        end
      end
      e_r: begin
        rev_v_o        = m_axi_rvalid_i;
        rev_data_o     = m_axi_rdata_i;
        rev_last_o     = m_axi_rlast_i;
        m_axi_rready_o = rev_ready_and_i;
        if (m_axi_rvalid_i && rev_ready_and_i) begin
          set_error = (m_axi_rresp_i != 2'b00);
          if (m_axi_rlast_i) state_n = e_ready;
        end
      end
      e_err_drain: begin
        fwd_ready_and_o = 1'b1;
        if (fwd_v_i && fwd_last_i) state_n = e_err_resp;
      end
      e_err_resp: begin
        rev_v_o    = 1'b1;
        rev_last_o = err_last;
        if (rev_ready_and_i && err_last) state_n = e_ready;
      end
      default: state_n = e_ready;
    endcase
  end

endmodule

// File: tb/tb_bp_zynq_dram_bridge.sv
// tb/tb_bp_zynq_dram_bridge.sv - directed self-checking bench for bp_zynq_dram_bridge
module tb_bp_zynq_dram_bridge;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        fwd_wr_i;
  logic [33:0] fwd_addr_i;
  logic [2:0]  fwd_size_i;
  logic [15:0] fwd_payload_i;
  logic [63:0] fwd_data_i;
  logic        fwd_last_i, fwd_v_i, fwd_ready_and_o;
  logic        rev_wr_o;
  logic [33:0] rev_addr_o;
  logic [2:0]  rev_size_o;
  logic [15:0] rev_payload_o;
  logic [63:0] rev_data_o;
  logic        rev_last_o, rev_v_o, rev_ready_and_i;
  logic [31:0] awaddr, araddr;
  logic [5:0]  awid, arid, bid, rid;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready, error_o;
  logic [63:0] wdata, rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  bp_zynq_dram_bridge dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .fwd_wr_i(fwd_wr_i), .fwd_addr_i(fwd_addr_i), .fwd_size_i(fwd_size_i),
    .fwd_payload_i(fwd_payload_i), .fwd_data_i(fwd_data_i), .fwd_last_i(fwd_last_i),
    .fwd_v_i(fwd_v_i), .fwd_ready_and_o(fwd_ready_and_o),
    .rev_wr_o(rev_wr_o), .rev_addr_o(rev_addr_o), .rev_size_o(rev_size_o),
    .rev_payload_o(rev_payload_o), .rev_data_o(rev_data_o), .rev_last_o(rev_last_o),
    .rev_v_o(rev_v_o), .rev_ready_and_i(rev_ready_and_i),
    .m_axi_awaddr_o(awaddr), .m_axi_awid_o(awid), .m_axi_awlen_o(awlen),
    .m_axi_awsize_o(awsize), .m_axi_awburst_o(awburst), .m_axi_awvalid_o(awvalid),
    .m_axi_awready_i(awready),
    .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb), .m_axi_wlast_o(wlast),
    .m_axi_wvalid_o(wvalid), .m_axi_wready_i(wready),
    .m_axi_bid_i(bid), .m_axi_bresp_i(bresp), .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready),
    .m_axi_araddr_o(araddr), .m_axi_arid_o(arid), .m_axi_arlen_o(arlen),
    .m_axi_arsize_o(arsize), .m_axi_arburst_o(arburst), .m_axi_arvalid_o(arvalid),
    .m_axi_arready_i(arready),
    .m_axi_rdata_i(rdata), .m_axi_rid_i(rid), .m_axi_rresp_i(rresp), .m_axi_rlast_i(rlast),
    .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready),
    .error_o(error_o)
  );

  task automatic idle();
    fwd_wr_i = 0; fwd_addr_i = '0; fwd_size_i = '0; fwd_payload_i = '0; fwd_data_i = '0;
    fwd_last_i = 0; fwd_v_i = 0; rev_ready_and_i = 0;
    awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0; arready = 0;
    rdata = '0; rid = '0; rresp = '0; rlast = 0; rvalid = 0;
  endtask

  task automatic drive_fwd(input logic wr, input logic [33:0] addr, input logic [2:0] size,
                           input logic [15:0] pl, input logic [63:0] data, input logic last);
    fwd_v_i = 1; fwd_wr_i = wr; fwd_addr_i = addr; fwd_size_i = size;
    fwd_payload_i = pl; fwd_data_i = data; fwd_last_i = last;
  endtask

  task automatic test_reset();
    reset_i = 1; idle();
    repeat (2) @(negedge clk_i);
    reset_i = 0; #1;
    checks++; if ({fwd_ready_and_o, rev_v_o, awvalid, wvalid, arvalid, bready, rready} !== 7'b0) begin
      errors++; $display("FAIL reset_handshakes got %b exp 0", {fwd_ready_and_o, rev_v_o, awvalid, wvalid, arvalid, bready, rready}); end
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL reset_error got %b exp 0", error_o); end
    checks++; if ({rev_wr_o, rev_addr_o, rev_size_o, rev_payload_o} !== '0) begin
      errors++; $display("FAIL reset_header got %h exp 0", {rev_wr_o, rev_addr_o, rev_size_o, rev_payload_o}); end
  endtask

  task automatic test_write_64b();
    @(negedge clk_i);
    drive_fwd(1, 34'h0_8000_1000, 3'd6, 16'h1234, 64'd0, 0); #1;
    checks++; if ({fwd_ready_and_o, awvalid} !== 2'b00) begin errors++; $display("FAIL w64_peek got %b exp 00", {fwd_ready_and_o, awvalid}); end
    @(negedge clk_i); #1;
    checks++; if ({awvalid, wvalid} !== 2'b10) begin errors++; $display("FAIL w64_awvalid got %b exp 10", {awvalid, wvalid}); end
    checks++; if ({awaddr, awlen, awsize, awburst, awid} !== {32'h1000, 8'd7, 3'd3, 2'b01, 6'd0}) begin
      errors++; $display("FAIL w64_aw got %h/%0d/%0d/%0d/%0d exp 1000/7/3/1/0", awaddr, awlen, awsize, awburst, awid); end
    awready = 1;
    @(negedge clk_i);
    awready = 0; wready = 1;
    for (int i = 0; i < 8; i++) begin
      fwd_data_i = 64'(i); fwd_last_i = (i == 7); #1;
      checks++; if ({wvalid, fwd_ready_and_o, wlast, wstrb, wdata} !== {1'b1, 1'b1, (i == 7), 8'hFF, 64'(i)}) begin
        errors++; $display("FAIL w64_beat%0d got v%b r%b l%b s%h d%h", i, wvalid, fwd_ready_and_o, wlast, wstrb, wdata); end
      @(negedge clk_i);
    end
    fwd_v_i = 0; wready = 0; bvalid = 1; bresp = 2'b00; rev_ready_and_i = 1; #1;
    checks++; if ({rev_v_o, rev_last_o, bready, rev_wr_o, rev_data_o, rev_payload_o} !== {4'b1111, 64'd0, 16'h1234}) begin
      errors++; $display("FAIL w64_rev got v%b l%b b%b w%b d%h p%h", rev_v_o, rev_last_o, bready, rev_wr_o, rev_data_o, rev_payload_o); end
    @(negedge clk_i);
    bvalid = 0; rev_ready_and_i = 0; #1;
    checks++; if ({rev_v_o, awvalid, error_o} !== 3'b000) begin errors++; $display("FAIL w64_done got %b exp 000", {rev_v_o, awvalid, error_o}); end
  endtask

  task automatic test_read_8b();
    @(negedge clk_i);
    drive_fwd(0, 34'h0_8000_0008, 3'd3, 16'hBEEF, 64'd0, 1);
    @(negedge clk_i); #1;
    checks++; if ({arvalid, fwd_ready_and_o, araddr, arlen, arsize, arburst} !== {2'b10, 32'h8, 8'd0, 3'd3, 2'b01}) begin
      errors++; $display("FAIL r8_ar got v%b r%b a%h l%0d s%0d", arvalid, fwd_ready_and_o, araddr, arlen, arsize); end
    arready = 1; #1;
    checks++; if (fwd_ready_and_o !== 1'b1) begin errors++; $display("FAIL r8_consume got %b exp 1", fwd_ready_and_o); end
    @(negedge clk_i);
    fwd_v_i = 0; arready = 0;
    rvalid = 1; rdata = 64'hDEADBEEF_CAFEF00D; rlast = 1; rev_ready_and_i = 1; #1;
    checks++; if ({rev_v_o, rev_last_o, rready, rev_wr_o, rev_data_o, rev_payload_o} !== {4'b1110, 64'hDEADBEEF_CAFEF00D, 16'hBEEF}) begin
      errors++; $display("FAIL r8_rev got v%b l%b rr%b w%b d%h p%h", rev_v_o, rev_last_o, rready, rev_wr_o, rev_data_o, rev_payload_o); end
    @(negedge clk_i);
    rvalid = 0; rlast = 0; rev_ready_and_i = 0; #1;
    checks++; if ({rev_v_o, arvalid} !== 2'b00) begin errors++; $display("FAIL r8_done got %b exp 00", {rev_v_o, arvalid}); end
  endtask

  task automatic test_write_2b();
    @(negedge clk_i);
    drive_fwd(1, 34'h0_8000_0006, 3'd1, 16'h0002, 64'hABCD, 1);
    @(negedge clk_i); #1;
    checks++; if ({awvalid, awaddr, awlen, awsize} !== {1'b1, 32'h6, 8'd0, 3'd1}) begin
      errors++; $display("FAIL w2_aw got v%b a%h l%0d s%0d exp 1/6/0/1", awvalid, awaddr, awlen, awsize); end
    awready = 1;
    @(negedge clk_i);
    awready = 0; wready = 1; #1;
    checks++; if ({wvalid, wlast, wstrb, wdata} !== {2'b11, 8'hC0, 64'hABCD}) begin
      errors++; $display("FAIL w2_w got v%b l%b s%h d%h exp 1/1/c0/abcd", wvalid, wlast, wstrb, wdata); end
    @(negedge clk_i);
    fwd_v_i = 0; wready = 0; bvalid = 1; rev_ready_and_i = 1;
    @(negedge clk_i);
    bvalid = 0; rev_ready_and_i = 0;
  endtask

  task automatic test_read_32b_backpressure();
    int k = 0;
    int c = 0;
    @(negedge clk_i);
    drive_fwd(0, 34'h0_8000_0100, 3'd5, 16'h0032, 64'd0, 1);
    @(negedge clk_i); #1;
    checks++; if ({arvalid, araddr, arlen, arsize} !== {1'b1, 32'h100, 8'd3, 3'd3}) begin
      errors++; $display("FAIL r32_ar got v%b a%h l%0d s%0d exp 1/100/3/3", arvalid, araddr, arlen, arsize); end
    arready = 1;
    @(negedge clk_i);
    fwd_v_i = 0; arready = 0;
    while (k < 4 && c < 20) begin
      rvalid = 1; rdata = 64'h1000 + 64'(k); rlast = (k == 3); rev_ready_and_i = (c % 2 == 0); #1;
      checks++; if ({rready, rev_v_o, rev_last_o, rev_data_o} !== {rev_ready_and_i, 1'b1, (k == 3), 64'h1000 + 64'(k)}) begin
        errors++; $display("FAIL r32_cycle%0d got rr%b v%b l%b d%h beat%0d", c, rready, rev_v_o, rev_last_o, rev_data_o, k); end
      if (rev_ready_and_i) k++;
      c++;
      @(negedge clk_i);
    end
    rvalid = 0; rlast = 0; rev_ready_and_i = 0; #1;
    checks++; if (k !== 4 || c !== 7) begin errors++; $display("FAIL r32_count got beats%0d cycles%0d exp 4/7", k, c); end
    checks++; if ({rev_v_o, rready} !== 2'b00) begin errors++; $display("FAIL r32_done got %b exp 00", {rev_v_o, rready}); end
  endtask

  task automatic test_bresp_error();
    @(negedge clk_i);
    drive_fwd(1, 34'h0_8000_0020, 3'd3, 16'h00EE, 64'h55, 1);
    @(negedge clk_i);
    awready = 1;
    @(negedge clk_i);
    awready = 0; wready = 1;
    @(negedge clk_i);
    fwd_v_i = 0; wready = 0; bvalid = 1; bresp = 2'b10; rev_ready_and_i = 1; #1;
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL berr_before got %b exp 0", error_o); end
    @(negedge clk_i);
    bvalid = 0; bresp = 0; rev_ready_and_i = 0; #1;
    checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL berr_set got %b exp 1", error_o); end
    test_read_8b();
    checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL berr_sticky got %b exp 1", error_o); end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk_i);
    drive_fwd(1, 34'h0_8000_0040, 3'd6, 16'h0077, 64'd0, 0);
    @(negedge clk_i);
    reset_i = 1;
    @(negedge clk_i);
    reset_i = 0; idle(); #1;
    checks++; if ({awvalid, wvalid, fwd_ready_and_o, error_o, rev_addr_o} !== '0) begin
      errors++; $display("FAIL rst_mid got aw%b w%b r%b e%b a%h exp 0", awvalid, wvalid, fwd_ready_and_o, error_o, rev_addr_o); end
  endtask

`ifdef BP_ZYNQ_DRAM_BOUNDS_CHECK_EN
  task automatic test_bounds();
    @(negedge clk_i);
    drive_fwd(0, 34'h0_0000_0000, 3'd4, 16'h0BAD, 64'd0, 1);
    @(negedge clk_i); #1;
    checks++; if ({arvalid, fwd_ready_and_o, error_o} !== 3'b011) begin
      errors++; $display("FAIL oob_drain got ar%b r%b e%b exp 0/1/1", arvalid, fwd_ready_and_o, error_o); end
    @(negedge clk_i);
    fwd_v_i = 0; rev_ready_and_i = 1; #1;
    checks++; if ({rev_v_o, rev_last_o, arvalid, rev_data_o} !== {3'b100, 64'd0}) begin
      errors++; $display("FAIL oob_beat0 got v%b l%b ar%b d%h exp 1/0/0/0", rev_v_o, rev_last_o, arvalid, rev_data_o); end
    @(negedge clk_i); #1;
    checks++; if ({rev_v_o, rev_last_o, arvalid, rev_data_o} !== {3'b110, 64'd0}) begin
      errors++; $display("FAIL oob_beat1 got v%b l%b ar%b d%h exp 1/1/0/0", rev_v_o, rev_last_o, arvalid, rev_data_o); end
    @(negedge clk_i);
    rev_ready_and_i = 0; #1;
    checks++; if ({rev_v_o, error_o} !== 2'b01) begin errors++; $display("FAIL oob_done got v%b e%b exp 0/1", rev_v_o, error_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_64b();
    test_read_8b();
    test_write_2b();
    test_read_32b_backpressure();
    test_bresp_error();
    test_reset_mid_burst();
`ifdef BP_ZYNQ_DRAM_BOUNDS_CHECK_EN
    test_reset();
    test_bounds();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
